// File: rtl/morse_sequencer.sv
// Morse letter sequencer: 4-deep letter FIFO feeding a LOAD/SEND/GAP FSM driven by symbol-period pulses.
// Optional MORSE_SEQ_DROPCNT_EN adds a saturating DropCount of rejected pushes.
module morse_sequencer (
    input  logic       ClockIn,
    input  logic       Reset,
    input  logic [2:0] LetterIn,
    input  logic       WordEndIn,
    input  logic       LetterValid,
    output logic       LetterReady,
    input  logic       NewBitIn,
    output logic       StartOut,
    output logic [2:0] LetterOut,
    output logic       Busy,
    output logic [2:0] Level,
`ifdef MORSE_SEQ_DROPCNT_EN
    output logic [7:0] DropCount,
`endif
    output logic       MsgDone
);

    typedef enum logic [1:0] {IDLE, LOAD, SEND, GAP} state_t;

    state_t     state;
    logic [3:0] fifo_mem [4];
    logic [1:0] wr_ptr, rd_ptr;
    logic       word_end;
    logic [3:0] bit_cnt;
    logic [2:0] gap_cnt;
    logic       push, pop;

    function automatic logic [3:0] letter_len(input logic [2:0] l);
        case (l)
            3'd0:    return 4'd5;
            3'd1:    return 4'd9;
            3'd2:    return 4'd11;
            3'd3:    return 4'd7;
            3'd4:    return 4'd1;
            3'd5:    return 4'd9;
            3'd6:    return 4'd9;
            default: return 4'd7;
        endcase
    endfunction

    // Ready comes from registered Level, so a full FIFO rejects even when popping this cycle.
    assign LetterReady = (Level != 3'd4);
    assign push        = LetterValid && LetterReady;
    assign pop         = (state == IDLE) && (Level != 3'd0);

    always_ff @(posedge ClockIn) begin
        if (push) fifo_mem[wr_ptr] <= {LetterIn, WordEndIn};
    end

    always_ff @(posedge ClockIn or posedge Reset) begin
        if (Reset) begin
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            Level  <= 3'd0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 2'd1;
            if (pop)  rd_ptr <= rd_ptr + 2'd1;
            Level <= Level + {2'b00, push} - {2'b00, pop};
        end
    end

    always_ff @(posedge ClockIn or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            LetterOut <= 3'd0;
            word_end  <= 1'b0;
            StartOut  <= 1'b0;
            Busy      <= 1'b0;
            MsgDone   <= 1'b0;
            bit_cnt   <= 4'd0;
            gap_cnt   <= 3'd0;
        end else begin
            StartOut <= 1'b0;
            MsgDone  <= 1'b0;
            case (state)
                IDLE: if (pop) begin
                    {LetterOut, word_end} <= fifo_mem[rd_ptr];
                    StartOut <= 1'b1;
                    Busy     <= 1'b1;
                    state    <= LOAD;
                end
                // StartOut is high throughout LOAD, so a coincident NewBitIn is never counted.
                LOAD: begin
                    bit_cnt <= letter_len(LetterOut);
                    state   <= SEND;
                end
                SEND: if (NewBitIn) begin
                    if (bit_cnt <= 4'd1) begin
                        bit_cnt <= 4'd0;
                        gap_cnt <= word_end ? 3'd7 : 3'd3;
                        state   <= GAP;
                    end else begin
                        bit_cnt <= bit_cnt - 4'd1;
                    end
                end
                GAP: if (NewBitIn) begin
                    if (gap_cnt <= 3'd1) begin
                        gap_cnt <= 3'd0;
                        Busy    <= 1'b0;
                        MsgDone <= (Level == 3'd0) && !push;
                        state   <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 3'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MORSE_SEQ_DROPCNT_EN
    always_ff @(posedge ClockIn or posedge Reset) begin
        if (Reset)
            DropCount <= 8'd0;
        else if (LetterValid && !LetterReady && DropCount != 8'hFF)
            DropCount <= DropCount + 8'd1;
    end
`endif

endmodule

// File: tb/tb_morse_sequencer.sv
// Directed bench for morse_sequencer; NewBitIn is a 1-in-4 pulse unless a test drives it by hand.
module tb_morse_sequencer;

    logic       ClockIn, Reset;
    logic [2:0] LetterIn;
    logic       WordEndIn, LetterValid, LetterReady, NewBitIn;
    logic       StartOut, Busy, MsgDone;
    logic [2:0] LetterOut, Level;
`ifdef MORSE_SEQ_DROPCNT_EN
    logic [7:0] DropCount;
`endif

    int checks = 0;
    int failures = 0;
    int auto_bit = 1;
    int div = 0;

    // Monitor log: letter and consumed-pulse count per StartOut.
    logic [2:0] log_letter [32];
    int         log_pulses [32];
    int         n_start = 0;
    int         n_done = 0;

    morse_sequencer dut (
        .ClockIn(ClockIn), .Reset(Reset), .LetterIn(LetterIn), .WordEndIn(WordEndIn),
        .LetterValid(LetterValid), .LetterReady(LetterReady), .NewBitIn(NewBitIn),
        .StartOut(StartOut), .LetterOut(LetterOut), .Busy(Busy), .Level(Level),
`ifdef MORSE_SEQ_DROPCNT_EN
        .DropCount(DropCount),
`endif
        .MsgDone(MsgDone)
    );

    initial ClockIn = 1'b0;
    always #5 ClockIn = ~ClockIn;

    always @(posedge ClockIn) begin
        if (StartOut) begin
            log_letter[n_start % 32] <= LetterOut;
            log_pulses[n_start % 32] <= 0;
            n_start <= n_start + 1;
        end else if (Busy && NewBitIn && n_start > 0) begin
            log_pulses[(n_start - 1) % 32] <= log_pulses[(n_start - 1) % 32] + 1;
        end
        if (MsgDone) n_done <= n_done + 1;
    end

    task automatic tick();
        @(negedge ClockIn);
        if (auto_bit != 0) begin
            div = (div + 1) % 4;
            NewBitIn = (div == 0);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse();
        tick(); NewBitIn = 1'b1;
        tick(); NewBitIn = 1'b0;
        tick(); tick();
    endtask

    task automatic test_reset();
        #2;
        checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0d exp=0", Busy); end
        checks++; if (Level !== 3'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", Level); end
        checks++; if (StartOut !== 1'b0) begin failures++; $display("FAIL reset_start got=%0d exp=0", StartOut); end
        checks++; if (MsgDone !== 1'b0) begin failures++; $display("FAIL reset_msgdone got=%0d exp=0", MsgDone); end
        checks++; if (LetterOut !== 3'd0) begin failures++; $display("FAIL reset_letter got=%0d exp=0", LetterOut); end
        checks++; if (LetterReady !== 1'b1) begin failures++; $display("FAIL reset_ready got=%0d exp=1", LetterReady); end
`ifdef MORSE_SEQ_DROPCNT_EN
        checks++; if (DropCount !== 8'd0) begin failures++; $display("FAIL reset_dropcnt got=%0d exp=0", DropCount); end
`endif
        run(3);
        Reset = 1'b0;
        run(3);
        checks++; if (Busy !== 1'b0 || StartOut !== 1'b0) begin failures++; $display("FAIL idle_after_reset busy=%0d start=%0d exp=0/0", Busy, StartOut); end
    endtask

    task automatic test_single_letter();
        int base = n_start;
        int bd = n_done;
        LetterIn = 3'd4; WordEndIn = 1'b0; LetterValid = 1'b1;
        tick(); LetterValid = 1'b0;
        run(4);
        checks++; if (Busy !== 1'b1) begin failures++; $display("FAIL e_busy got=%0d exp=1", Busy); end
        run(40);
        checks++; if (n_start - base != 1) begin failures++; $display("FAIL e_starts got=%0d exp=1", n_start - base); end
        checks++; if (log_letter[base % 32] !== 3'd4) begin failures++; $display("FAIL e_letter got=%0d exp=4", log_letter[base % 32]); end
        checks++; if (log_pulses[base % 32] != 4) begin failures++; $display("FAIL e_pulses got=%0d exp=4", log_pulses[base % 32]); end
        checks++; if (n_done - bd != 1) begin failures++; $display("FAIL e_msgdone got=%0d exp=1", n_done - bd); end
        checks++; if (Level !== 3'd0 || Busy !== 1'b0) begin failures++; $display("FAIL e_end level=%0d busy=%0d exp=0/0", Level, Busy); end
    endtask

    task automatic test_two_letters();
        int base = n_start;
        int bd = n_done;
        LetterIn = 3'd0; WordEndIn = 1'b0; LetterValid = 1'b1;
        tick(); LetterIn = 3'd3; WordEndIn = 1'b1;
        tick(); LetterValid = 1'b0; WordEndIn = 1'b0;
        run(130);
        checks++; if (n_start - base != 2) begin failures++; $display("FAIL ad_starts got=%0d exp=2", n_start - base); end
        checks++; if (log_letter[base % 32] !== 3'd0) begin failures++; $display("FAIL ad_letter0 got=%0d exp=0", log_letter[base % 32]); end
        checks++; if (log_letter[(base + 1) % 32] !== 3'd3) begin failures++; $display("FAIL ad_letter1 got=%0d exp=3", log_letter[(base + 1) % 32]); end
        checks++; if (log_pulses[base % 32] != 8) begin failures++; $display("FAIL ad_pulses0 got=%0d exp=8", log_pulses[base % 32]); end
        checks++; if (log_pulses[(base + 1) % 32] != 14) begin failures++; $display("FAIL ad_pulses1 got=%0d exp=14", log_pulses[(base + 1) % 32]); end
        checks++; if (n_done - bd != 1) begin failures++; $display("FAIL ad_msgdone got=%0d exp=1", n_done - bd); end
    endtask

    task automatic test_fill();
        logic [2:0] lts [6];
        int         exp_p [5];
        int         base = n_start;
        int         bd = n_done;
        lts = '{3'd4, 3'd0, 3'd3, 3'd7, 3'd1, 3'd2};
        exp_p = '{4, 8, 10, 10, 12};
        WordEndIn = 1'b0;
        for (int i = 0; i < 5; i++) begin
            LetterIn = lts[i]; LetterValid = 1'b1;
            tick();
        end
        checks++; if (Level !== 3'd4 || LetterReady !== 1'b0) begin failures++; $display("FAIL fill_full level=%0d ready=%0d exp=4/0", Level, LetterReady); end
        LetterIn = lts[5];
        tick(); LetterValid = 1'b0;
        checks++; if (Level !== 3'd4) begin failures++; $display("FAIL fill_reject level=%0d exp=4", Level); end
        run(260);
        checks++; if (n_start - base != 5) begin failures++; $display("FAIL fill_starts got=%0d exp=5", n_start - base); end
        for (int i = 0; i < 5; i++) begin
            checks++; if (log_letter[(base + i) % 32] !== lts[i]) begin failures++; $display("FAIL fill_order%0d got=%0d exp=%0d", i, log_letter[(base + i) % 32], lts[i]); end
            checks++; if (log_pulses[(base + i) % 32] != exp_p[i]) begin failures++; $display("FAIL fill_pulses%0d got=%0d exp=%0d", i, log_pulses[(base + i) % 32], exp_p[i]); end
        end
        checks++; if (Level !== 3'd0 || n_done - bd != 1) begin failures++; $display("FAIL fill_end level=%0d done=%0d exp=0/1", Level, n_done - bd); end
    endtask

    task automatic test_reset_mid();
        int base;
        LetterIn = 3'd2; WordEndIn = 1'b0; LetterValid = 1'b1;
        tick(); LetterValid = 1'b0;
        run(6);
        LetterValid = 1'b1; LetterIn = 3'd0;
        tick(); LetterIn = 3'd1;
        tick(); LetterIn = 3'd3;
        tick(); LetterValid = 1'b0;
        run(2);
        checks++; if (Level !== 3'd3 || Busy !== 1'b1) begin failures++; $display("FAIL mid_pre level=%0d busy=%0d exp=3/1", Level, Busy); end
        Reset = 1'b1;
        #1;
        checks++; if (Busy !== 1'b0 || Level !== 3'd0 || StartOut !== 1'b0 || LetterReady !== 1'b1) begin
            failures++; $display("FAIL mid_reset busy=%0d level=%0d start=%0d ready=%0d exp=0/0/0/1", Busy, Level, StartOut, LetterReady);
        end
        tick(); Reset = 1'b0;
        base = n_start;
        run(60);
        checks++; if (n_start != base || Busy !== 1'b0) begin failures++; $display("FAIL mid_after starts=%0d busy=%0d exp=0/0", n_start - base, Busy); end
    endtask

    task automatic test_start_coincident();
        int bd = n_done;
        int found = 0;
        auto_bit = 0; NewBitIn = 1'b0;
        tick();
        LetterIn = 3'd1; WordEndIn = 1'b0; LetterValid = 1'b1;
        tick(); LetterValid = 1'b0;
        for (int i = 0; i < 10 && found == 0; i++) begin
            tick();
            if (StartOut === 1'b1) found = 1;
        end
        checks++; if (found == 0) begin failures++; $display("FAIL coin_start got=0 exp=1"); end
        checks++; if (LetterOut !== 3'd1) begin failures++; $display("FAIL coin_letter got=%0d exp=1", LetterOut); end
        NewBitIn = 1'b1;
        tick(); NewBitIn = 1'b0;
        for (int i = 0; i < 11; i++) pulse();
        checks++; if (Busy !== 1'b1) begin failures++; $display("FAIL coin_busy11 got=%0d exp=1", Busy); end
        pulse();
        checks++; if (Busy !== 1'b0 || n_done - bd != 1) begin failures++; $display("FAIL coin_end busy=%0d done=%0d exp=0/1", Busy, n_done - bd); end
        auto_bit = 1;
    endtask

`ifdef MORSE_SEQ_DROPCNT_EN
    task automatic test_dropcnt();
        auto_bit = 0; NewBitIn = 1'b0;
        tick();
        LetterIn = 3'd2; WordEndIn = 1'b0; LetterValid = 1'b1;
        run(305);
        checks++; if (DropCount !== 8'd255) begin failures++; $display("FAIL drop_sat got=%0d exp=255", DropCount); end
        run(5);
        checks++; if (DropCount !== 8'd255) begin failures++; $display("FAIL drop_hold got=%0d exp=255", DropCount); end
        LetterValid = 1'b0;
        Reset = 1'b1;
        #1;
        checks++; if (DropCount !== 8'd0) begin failures++; $display("FAIL drop_reset got=%0d exp=0", DropCount); end
        tick(); Reset = 1'b0;
        auto_bit = 1;
    endtask
`endif

    initial begin
        Reset = 1'b1; LetterIn = 3'd0; WordEndIn = 1'b0; LetterValid = 1'b0; NewBitIn = 1'b0;
        test_reset();
        test_single_letter();
        test_two_letters();
        test_fill();
        test_reset_mid();
        test_start_coincident();
`ifdef MORSE_SEQ_DROPCNT_EN
        test_dropcnt();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/morse_sequencer.md
MORSE_SEQUENCER -- requirements
Module: morse_sequencer

Interface
REQ-001 The block SHALL have these ports, each `name  direction  width  meaning`, clock and reset first:
- ClockIn  in  1  sole clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- LetterIn  in  3  letter code; 0=A through 7=H.
- WordEndIn  in  1  the pushed letter ends a word.
- LetterValid  in  1  push request.
- LetterReady  out  1  FIFO can accept a push.
- NewBitIn  in  1  one-cycle symbol-period pulse from the rate divider.
- StartOut  out  1  one-cycle load/restart to the shifter and rate divider.
- LetterOut  out  3  letter code presented to the Morse LUT.
- Busy  out  1  a letter or gap is in progress.
- Level  out  3  FIFO occupancy, 0..4.
- MsgDone  out  1  one-cycle pulse when the last queued gap completes.

REQ-002 The block SHALL use one clock, ClockIn; reset is asynchronous and active-high (Reset).

Function
REQ-003 The block SHALL hold a 4-entry FIFO of {LetterIn, WordEndIn}.
REQ-004 A push SHALL occur on any ClockIn edge where LetterValid=1 and LetterReady=1.
REQ-005 LetterReady SHALL equal (Level!=4), evaluated before any pop in the same cycle.
REQ-006 When full, a push SHALL be rejected even if a pop occurs in the same cycle; there is no overwrite and no error.
REQ-007 FIFO pointers SHALL wrap modulo 4.
REQ-008 Level SHALL update to the post-push/pop value one cycle after the edge.
REQ-009 The FSM SHALL have four states: IDLE, LOAD, SEND, GAP.
REQ-010 In IDLE with Level>0, the FSM SHALL pop the head entry, register it into LetterOut/WordEnd, and go to LOAD.
REQ-011 In IDLE with Level=0, the FSM SHALL stay in IDLE.
REQ-012 A letter pushed into an empty FIFO SHALL be popped no earlier than the next cycle.
REQ-013 In LOAD, StartOut SHALL be 1 for exactly one cycle.
REQ-014 On leaving LOAD, BitCnt SHALL load the letter length in symbol units, and the FSM SHALL go to SEND.
REQ-015 Letter lengths SHALL be: A=5, B=9, C=11, D=7, E=1, F=9, G=9, H=7.
REQ-016 In SEND, each NewBitIn pulse SHALL decrement BitCnt.
REQ-017 The pulse that takes BitCnt from 1 to 0 SHALL load GapCnt and move the FSM to GAP.
REQ-018 GapCnt SHALL be 7 if WordEnd is set, else 3.
REQ-019 In GAP, each NewBitIn pulse SHALL decrement GapCnt.
REQ-020 The pulse that takes GapCnt from 1 to 0 SHALL return the FSM to IDLE.
REQ-021 On that same edge, MsgDone SHALL pulse for one cycle if Level=0 and no push occurs that cycle.
REQ-022 NewBitIn SHALL be ignored in IDLE and LOAD.
REQ-023 NewBitIn coincident with StartOut SHALL NOT be counted.
REQ-024 Busy SHALL be 1 in LOAD, SEND and GAP, and 0 in IDLE.
REQ-025 LetterOut SHALL hold its value from pop until the next pop; the shifter drains zeros during GAP.
REQ-026 All outputs SHALL be registered except LetterReady, which is derived from registered Level.

Reset
REQ-027 Reset=1 SHALL immediately force: FSM=IDLE, FIFO pointers=0, Level=0, LetterOut=0, StartOut=0, Busy=0, MsgDone=0, BitCnt=0, GapCnt=0, and LetterReady=1.
REQ-028 Reset mid-letter SHALL discard the in-flight letter and all queued entries; no StartOut SHALL be issued until a new push follows reset release.

Configuration
REQ-029 With MORSE_SEQ_DROPCNT_EN defined, the block SHALL add an output DropCount[7:0].
REQ-030 DropCount SHALL increment on each edge with LetterValid=1 and LetterReady=0, SHALL saturate at 255, and SHALL be cleared by Reset.
REQ-031 Without MORSE_SEQ_DROPCNT_EN, the DropCount port and its counter SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-032 The bench SHALL cover these scenarios, with NewBitIn stubbed as a 1-cycle pulse every 4 cycles:
- Push E (4), WordEnd=0, idle FIFO -> StartOut pulse with LetterOut=4; Busy for 1 counted pulse plus 3 gap pulses; MsgDone pulses once; Level returns to 0.
- Push A then D with WordEnd=1 on D -> two StartOut pulses; the first is followed by 5+3 counted pulses and the second by 7+7; LetterOut=0 then 3.
- Push 6 letters on consecutive cycles while idle -> first popped, next 4 accepted, 6th rejected; LetterReady=0 while Level=4; exactly 5 letters transmitted in push order.
- Assert Reset during SEND of C (2) with 3 entries queued -> Busy=0, Level=0 and StartOut=0 immediately; no further StartOut after release without a new push.
- NewBitIn asserted in the same cycle as StartOut -> not counted; letter B still consumes 9 subsequent pulses.
- With MORSE_SEQ_DROPCNT_EN: 300 pushes while full -> DropCount=255, held; Reset -> 0.
